// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: processes D bits per cycle, LSB digit first,
// and presents the full result plus carry/overflow flags on completion.
module addsub_serial #(
  parameter int unsigned N    = 8,
  parameter int unsigned D    = 2,
  parameter int unsigned SIGN = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         op_i,
  input  logic [N-1:0] data0_i,
  input  logic [N-1:0] data1_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] data_o,
  output logic         carry_o,
  output logic         over_o
);

  localparam int unsigned ND = N / D;
  localparam int unsigned CW = (ND > 1) ? $clog2(ND) : 1;
  localparam int unsigned DW = D + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  res_q;
  logic [N-1:0]  res_d;
  logic          op_q;
  logic          carry_q;
  logic [CW-1:0] cnt_q;

  logic [D-1:0]  a_dig;
  logic [D-1:0]  b_dig;
  logic [D:0]    sum_c;
  logic          cin_msb_c;
  logic          last_c;
  logic          accept_c;
  logic          over_c;

  // One digit of the ripple: operand digits are always the low D bits because
  // the operand registers shift right as digits are consumed.
  always_comb begin
    a_dig     = a_q[D-1:0];
    b_dig     = op_q ? ~b_q[D-1:0] : b_q[D-1:0];
    sum_c     = {1'b0, a_dig} + {1'b0, b_dig} + DW'(carry_q);
    cin_msb_c = a_dig[D-1] ^ b_dig[D-1] ^ sum_c[D-1];
    last_c    = (cnt_q == CW'(ND - 1));
    if (SIGN != 0) begin
      over_c = cin_msb_c ^ sum_c[D];
    end else begin
      over_c = op_q ? ~sum_c[D] : sum_c[D];
    end
  end

  // Result digits enter at the top and shift down so they land in place after ND steps.
  generate
    if (D == N) begin : g_full
      assign res_d = sum_c[D-1:0];
    end else begin : g_shift
      assign res_d = {sum_c[D-1:0], res_q[N-1:D]};
    end
  endgenerate

  // Next-state logic; a start is honoured in any state except RUN.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start_i) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: operand load, digit processing and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      data_o  <= '0;
      carry_o <= 1'b0;
      over_o  <= 1'b0;
    end else begin
      busy_o <= (state_d == RUN);
      done_o <= (state_d == DONE);
      if (accept_c) begin
        a_q     <= data0_i;
        b_q     <= data1_i;
        op_q    <= op_i;
        carry_q <= op_i;
        cnt_q   <= '0;
        res_q   <= '0;
      end else if (state_q == RUN) begin
        a_q     <= a_q >> D;
        b_q     <= b_q >> D;
        res_q   <= res_d;
        carry_q <= sum_c[D];
        cnt_q   <= cnt_q + CW'(1);
        if (last_c) begin
          data_o  <= res_d;
          carry_o <= sum_c[D];
          over_o  <= over_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial (N=8, D=2) with unsigned and signed instances.
module tb_addsub_serial;

  localparam int unsigned LAT = 4;

  typedef struct {
    logic [7:0]  data;
    logic        carry;
    logic        over;
    int unsigned due;
  } exp_t;

  logic       clk;
  logic       rst_i;
  logic       start_i;
  logic       op_i;
  logic [7:0] d0;
  logic [7:0] d1;

  logic       busy0, done0, carry0, over0;
  logic [7:0] dout0;
  logic       busy1, done1, carry1, over1;
  logic [7:0] dout1;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0;
  exp_t        e1;

  addsub_serial #(.N(8), .D(2), .SIGN(0)) u_uns (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .data0_i(d0), .data1_i(d1),
    .busy_o(busy0), .done_o(done0), .data_o(dout0), .carry_o(carry0), .over_o(over0)
  );

  addsub_serial #(.N(8), .D(2), .SIGN(1)) u_sgn (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .data0_i(d0), .data1_i(d1),
    .busy_o(busy1), .done_o(done1), .data_o(dout1), .carry_o(carry1), .over_o(over1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: integer arithmetic with range checks for overflow.
  function automatic exp_t model(bit sgn, bit op, logic [7:0] a, logic [7:0] b, int unsigned due);
    exp_t e;
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int r;
    if (!op) begin
      r = ua + ub;
      e.carry = (r > 255);
    end else begin
      r = ua - ub;
      e.carry = (ua >= ub);
    end
    e.data = 8'(r);
    if (sgn) begin
      r = op ? (sa - sb) : (sa + sb);
      e.over = (r > 127) || (r < -128);
    end else begin
      e.over = op ? !e.carry : e.carry;
    end
    e.due = due;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT signals completion.
  always @(negedge clk) begin
    if ((busy0 && done0) || (busy1 && done1)) begin
      miscompares++;
      $display("FAIL busy_done_overlap: busy=%b/%b done=%b/%b required no overlap", busy0, busy1, done0, done1);
    end
    if (done0) begin
      vectors++;
      if (q0.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done_uns: done_o high at cycle %0d with nothing pending", cyc);
      end else begin
        e0 = q0.pop_front();
        if (dout0 !== e0.data || carry0 !== e0.carry || over0 !== e0.over || cyc != e0.due) begin
          miscompares++;
          $display("FAIL result_uns: got data=%h c=%b o=%b cyc=%0d required data=%h c=%b o=%b cyc=%0d",
                   dout0, carry0, over0, cyc, e0.data, e0.carry, e0.over, e0.due);
        end
      end
    end
    if (done1) begin
      vectors++;
      if (q1.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done_sgn: done_o high at cycle %0d with nothing pending", cyc);
      end else begin
        e1 = q1.pop_front();
        if (dout1 !== e1.data || carry1 !== e1.carry || over1 !== e1.over || cyc != e1.due) begin
          miscompares++;
          $display("FAIL result_sgn: got data=%h c=%b o=%b cyc=%0d required data=%h c=%b o=%b cyc=%0d",
                   dout1, carry1, over1, cyc, e1.data, e1.carry, e1.over, e1.due);
        end
      end
    end
  end

  // Drive a start at the current negedge; expectation is queued once the edge has sampled it.
  task automatic issue(bit op, logic [7:0] a, logic [7:0] b);
    start_i = 1'b1;
    op_i    = op;
    d0      = a;
    d1      = b;
    @(negedge clk);
    q0.push_back(model(1'b0, op, a, b, cyc + LAT));
    q1.push_back(model(1'b1, op, a, b, cyc + LAT));
    start_i = 1'b0;
    d0      = 8'($urandom);
    d1      = 8'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0) return;
    end
    miscompares++;
    $display("FAIL done_timeout: no done_o within 12 cycles");
  endtask

  logic [16:0] dir_tbl [6];

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    op_i    = 1'b0;
    d0      = 8'h00;
    d1      = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_done", 32'(done0), 32'd0);
    chk("reset_data", 32'(dout0), 32'd0);
    chk("reset_flags", 32'({carry0, over0, carry1, over1}), 32'd0);
    rst_i = 1'b0;

    // {op, data0, data1}
    dir_tbl[0] = {1'b1, 8'h05, 8'h03};
    dir_tbl[1] = {1'b1, 8'h03, 8'h05};
    dir_tbl[2] = {1'b0, 8'hFF, 8'h01};
    dir_tbl[3] = {1'b0, 8'h7F, 8'h01};
    dir_tbl[4] = {1'b1, 8'h80, 8'h01};
    dir_tbl[5] = {1'b1, 8'h01, 8'h02};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue(dir_tbl[i][16], dir_tbl[i][15:8], dir_tbl[i][7:0]);
      wait_done();
    end

    // Start during RUN must be ignored.
    @(negedge clk);
    issue(1'b0, 8'h10, 8'h01);
    start_i = 1'b1; op_i = 1'b0; d0 = 8'h20; d1 = 8'h02;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    chk("ignored_start_data", 32'(dout0), 32'h11);
    repeat (6) @(negedge clk);

    // Back-to-back: start held in DONE re-enters RUN directly.
    @(negedge clk);
    issue(1'b0, 8'h10, 8'h20);
    wait_done();
    issue(1'b0, 8'h01, 8'h01);
    chk("b2b_busy", 32'(busy0), 32'd1);
    wait_done();
    chk("b2b_data", 32'(dout0), 32'h02);

    // Reset in the middle of RUN.
    @(negedge clk);
    issue(1'b0, 8'h33, 8'h44);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("midrun_rst_busy", 32'({busy0, busy1}), 32'd0);
    chk("midrun_rst_done", 32'({done0, done1}), 32'd0);
    chk("midrun_rst_data", 32'({dout0, dout1}), 32'd0);
    chk("midrun_rst_flags", 32'({carry0, over0, carry1, over1}), 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_i = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk);
    issue(1'b1, 8'h0A, 8'h05);
    wait_done();
    chk("post_rst_data", 32'(dout0), 32'h05);

    // Random traffic; a zero gap exercises the DONE -> RUN path.
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(1'($urandom), 8'($urandom), 8'($urandom));
      wait_done();
    end

    repeat (8) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL pending_left: %0d/%0d results never completed, required 0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter D, default 2, meaning bits processed per cycle; N SHALL be an integer multiple of D, and 1 <= D <= N.
REQ-003 The block SHALL have parameter SIGN, default 0, meaning 0 for unsigned and 1 for two's-complement overflow rules.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock, all state on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port start_i, input, 1 bit: request a new operation.
REQ-007 The block SHALL have port op_i, input, 1 bit: 0 = add, 1 = subtract (data0_i - data1_i).
REQ-008 The block SHALL have ports data0_i and data1_i, input, N bits each: operands.
REQ-009 The block SHALL have port busy_o, output, 1 bit: high while in RUN.
REQ-010 The block SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port data_o, output, N bits: result, registered.
REQ-012 The block SHALL have port carry_o, output, 1 bit: raw carry out of the MSB digit.
REQ-013 The block SHALL have port over_o, output, 1 bit: overflow/borrow flag per REQ-021.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start_i = 1 SHALL latch op_i, data0_i and data1_i, clear the digit counter, preset the carry register to op_i, and enter RUN on the next edge.
REQ-016 start_i in RUN SHALL be ignored; latched operands, counter and carry SHALL be unaffected.
REQ-017 In RUN, each cycle SHALL add digit k of data0 and digit k of (op ? ~data1 : data1) plus the carry register, LSB digit first, write the D-bit sum into digit k of the result register, and update the carry register.
REQ-018 After the digit at index N/D-1 is processed, the FSM SHALL enter DONE; with start_i sampled high at edge t, done_o SHALL be high in the cycle following edge t+N/D, for exactly one cycle.
REQ-019 DONE SHALL last one cycle, then return to IDLE unless start_i is accepted per REQ-015.
REQ-020 carry_o SHALL equal the carry out of the MSB digit; for subtract, carry_o = 1 means no borrow.
REQ-021 over_o SHALL be: SIGN=0 add -> carry_o; SIGN=0 subtract -> ~carry_o (borrow, data0 < data1); SIGN=1 -> carry into MSB XOR carry out of MSB.
REQ-022 data_o, carry_o and over_o SHALL update only at the transition into DONE and hold until the next completion; intermediate digits SHALL NOT be visible on data_o.
REQ-023 busy_o SHALL be high exactly in RUN; done_o and busy_o SHALL never be high together.
REQ-024 The case D = N SHALL complete in one RUN cycle.

Reset
REQ-025 rst_i high SHALL immediately force IDLE, with busy_o = 0, done_o = 0, data_o = 0, carry_o = 0, over_o = 0, and counter, carry and operand registers cleared.
REQ-026 Reset mid-RUN SHALL abort the operation with no done_o pulse; the first start_i after rst_i falls SHALL be handled normally.

Verification (N=8, D=2, so the latency is 4 cycles)
REQ-027 SIGN=0, sub 0x05-0x03 -> done_o high 4 cycles after the start edge, data_o=0x02, carry_o=1, over_o=0.
REQ-028 SIGN=0, sub 0x03-0x05 -> data_o=0xFE, carry_o=0, over_o=1; add 0xFF+0x01 -> data_o=0x00, carry_o=1, over_o=1.
REQ-029 SIGN=1, add 0x7F+0x01 -> data_o=0x80, over_o=1; sub 0x80-0x01 -> data_o=0x7F, over_o=1; sub 0x01-0x02 -> data_o=0xFF, over_o=0.
REQ-030 Start 0x10+0x01, then pulse start_i with 0x20+0x02 during RUN -> a single done_o, data_o=0x11.
REQ-031 Assert rst_i during RUN cycle 2 -> all outputs 0 immediately and no done_o; a new start of 0x0A-0x05 -> data_o=0x05 after 4 cycles.
REQ-032 start_i held high in DONE with 0x01+0x01 -> RUN re-entered without an IDLE cycle, and the second done_o comes 4 cycles later with data_o=0x02.
